input_mask_sequencer: RTL and testbench
=======================================

# input_mask_sequencer

Upstream feeder for the delay-feedback reservoir. Accepts one input sample per frame over a valid/ready handshake. Multiplies the sample by a per-virtual-node fixed-point mask held in an internal writable mask table. Sequences the resulting masked values into the reservoir, one virtual node at a time, by driving the reservoir's `din`/`en` and obeying its `reservoir_valid` completion signal.

## Interface
- `VIRTUAL_NODES`, 10: mask entries, equal to reservoir injections per frame.
- `DATA_WIDTH`, 32: sample width and reservoir `din` width, unsigned.
- `MASK_WIDTH`, 16: mask entry width, unsigned fraction Q0.MASK_WIDTH.
- `ADDR_WIDTH`, `$clog2(VIRTUAL_NODES)`: mask address and node index width.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous reset, active-low (low resets).
- `sample_valid` in 1: upstream sample present.
- `sample_data` in DATA_WIDTH: sample value.
- `sample_ready` out 1: high only in IDLE.
- `mask_wr_en` in 1: mask table write strobe.
- `mask_wr_addr` in ADDR_WIDTH: entry to write; writes with address ≥ VIRTUAL_NODES are ignored.
- `mask_wr_data` in MASK_WIDTH: mask value.
- `res_din` out DATA_WIDTH: masked value to the reservoir `din`.
- `res_en` out 1: one-cycle inject pulse to the reservoir `en`.
- `res_valid` in 1: the reservoir's `reservoir_valid`.
- `node_idx` out ADDR_WIDTH: index of the node currently being processed.
- `busy` out 1: high in any state other than IDLE.
- `frame_done` out 1: one-cycle pulse after the last node completes.

## Operation
- The mask table is a VIRTUAL_NODES × MASK_WIDTH register array, and all entries reset to 0.
  - A write is accepted only when `busy` = 0.
  - Writes while busy are dropped. There is no read-back port.
- Sample capture: a sample is captured on the cycle where `sample_valid` and `sample_ready` are both 1. The sample is held in an internal register for the whole frame.
- Masked value: product = sample × mask[node_idx], a full (DATA_WIDTH+MASK_WIDTH)-bit unsigned result.
  - `res_din` = product[DATA_WIDTH+MASK_WIDTH-1 : MASK_WIDTH], truncated with no rounding.
  - It is registered in MULT and held stable until the next MULT.
- State machine:
  - IDLE: `sample_ready` = 1. On handshake, capture the sample, set node_idx = 0, and go to MULT.
  - MULT: register the product for node_idx, then go to ISSUE.
  - ISSUE: `res_en` = 1 for exactly this cycle, then go to SETTLE.
  - SETTLE: `res_en` = 0 and `res_valid` is ignored, because the reservoir is mid-update and its valid output is low. Go to WAIT.
  - WAIT: stay while `res_valid` = 0. When `res_valid` = 1:
    - if node_idx = VIRTUAL_NODES-1, pulse `frame_done` and go to IDLE;
    - otherwise increment node_idx and go to MULT.
  - Any unused encoding goes to IDLE.
- `node_idx` wraps to 0 on return to IDLE.

## Timing
- Reset values:
  - state = IDLE, `sample_ready` = 1;
  - `res_en`, `busy`, `frame_done` = 0;
  - `res_din`, `node_idx` = 0, and the mask table = 0.
- Reset asserted mid-frame aborts the frame immediately (asynchronously):
  - `res_en` drops at once and no `frame_done` is issued;
  - the mask table is also cleared.
- Per node, with the reservoir answering immediately: 4 cycles (MULT, ISSUE, SETTLE, WAIT). A frame from handshake to the `frame_done` cycle takes 4×VIRTUAL_NODES cycles; IDLE is re-entered on the next cycle.
- `frame_done` is asserted in the final WAIT cycle, the same cycle `res_valid` is seen high. `sample_ready` rises on the following cycle, so back-to-back frames have a 1-cycle IDLE gap.
- `sample_valid` asserted while busy is not acknowledged, and the upstream must hold its data.
- A mask write and a sample handshake in the same IDLE cycle: the write lands first and is used by the frame.
- `res_valid` stuck low leaves the block in WAIT indefinitely. There is no timeout; only reset recovers.

## Test plan
- Reset: hold `rst` = 0 → `sample_ready` = 1, `res_en` = 0, `res_din` = 0, `busy` = 0. Start a frame with the mask at its reset value → all 10 `res_din` values are 0.
- Basic frame:
  - setup: mask[k] = 0x8000 for all k; sample 0x0001_0000; reservoir model responds immediately;
  - required: 10 `res_en` pulses exactly 4 cycles apart, each with `res_din` = 0x0000_8000;
  - required: `frame_done` at cycle 40 after the handshake.
- Full-scale truncation: mask[3] = 0xFFFF, sample 0xFFFF_FFFF → node 3 `res_din` = 0xFFFE_FFFF. Mask 0 → `res_din` = 0.
- Stall: hold `res_valid` low for 5 extra cycles at node 2 → no extra `res_en`, `node_idx` stays 2, and the frame lengthens by exactly 5 cycles.
- Busy protections:
  - a mask write to entry 0 mid-frame is dropped (next frame still uses the old value);
  - `sample_valid` while busy gets no acknowledge;
  - a write to address 12 in IDLE changes nothing.
- Abort: assert reset during node 5's SETTLE → outputs return to reset values at once, no `frame_done` is issued, and a new frame after release starts at node 0.

Source files
------------

// File: rtl/input_mask_sequencer.sv
// input_mask_sequencer
//   Feeds the delay-feedback reservoir. It takes one sample per frame, scales it
//   by each virtual node's Q0.MASK_WIDTH mask entry, and injects the scaled
//   values into the reservoir one node at a time. Before each next node it
//   waits for the reservoir's completion signal.
// Ports:
//   clk, rst                          clock, async active-low reset
//   sample_valid/sample_data/ready    upstream sample handshake (ready only in IDLE)
//   mask_wr_en/addr/data              mask table write port (ignored while busy)
//   res_din, res_en, res_valid        reservoir din / inject pulse / reservoir_valid
//   node_idx, busy, frame_done        progress and status outputs

// One mask table entry. It clears on reset and loads on its write strobe.
module ims_mask_entry #(
  parameter int MASK_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [MASK_WIDTH-1:0] d,
  output logic [MASK_WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst)    q <= '0;
    else if (we) q <= d;
endmodule

module input_mask_sequencer #(
  parameter int VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int MASK_WIDTH    = 16,
  parameter int ADDR_WIDTH    = $clog2(VIRTUAL_NODES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  sample_ready,
  input  logic                  mask_wr_en,
  input  logic [ADDR_WIDTH-1:0] mask_wr_addr,
  input  logic [MASK_WIDTH-1:0] mask_wr_data,
  output logic [DATA_WIDTH-1:0] res_din,
  output logic                  res_en,
  input  logic                  res_valid,
  output logic [ADDR_WIDTH-1:0] node_idx,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int PW = DATA_WIDTH + MASK_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(VIRTUAL_NODES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MULT   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;

  logic [2:0]                                 state;
  logic [DATA_WIDTH-1:0]                      sample_q;
  logic [VIRTUAL_NODES-1:0][MASK_WIDTH-1:0]   mask_q;
  logic [VIRTUAL_NODES-1:0]                   mask_we;
  logic [MASK_WIDTH-1:0]                      mask_sel;
  logic [PW-1:0]                              prod;

  // An address outside the table decodes to no entry, so that write is dropped.
  for (genvar i = 0; i < VIRTUAL_NODES; i++) begin : g_mask
    assign mask_we[i] = mask_wr_en && !busy && (mask_wr_addr == ADDR_WIDTH'(i));
    ims_mask_entry #(.MASK_WIDTH(MASK_WIDTH)) u_entry (
      .clk (clk),
      .rst (rst),
      .we  (mask_we[i]),
      .d   (mask_wr_data),
      .q   (mask_q[i])
    );
  end

  always_comb begin
    mask_sel = '0;
    for (int i = 0; i < VIRTUAL_NODES; i++)
      if (node_idx == ADDR_WIDTH'(i)) mask_sel = mask_q[i];
  end

  assign prod = {{MASK_WIDTH{1'b0}}, sample_q} * {{DATA_WIDTH{1'b0}}, mask_sel};

  // The status outputs are decoded straight from state. A reset therefore
  // drops res_en and frame_done without waiting for a clock edge.
  assign sample_ready = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign res_en       = (state == S_ISSUE);
  assign frame_done   = (state == S_WAIT) && res_valid && (node_idx == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      sample_q <= '0;
      res_din  <= '0;
      node_idx <= '0;
    end else begin
      case (state)
        S_IDLE: if (sample_valid) begin
          sample_q <= sample_data;
          node_idx <= '0;
          state    <= S_MULT;
        end
        S_MULT: begin
          // Keep the integer part of the product. The fraction is truncated.
          res_din <= DATA_WIDTH'(prod >> MASK_WIDTH);
          state   <= S_ISSUE;
        end
        S_ISSUE:  state <= S_SETTLE;
        // The reservoir's valid output is low while it updates, so skip one cycle.
        S_SETTLE: state <= S_WAIT;
        S_WAIT: if (res_valid) begin
          if (node_idx == LAST) begin
            node_idx <= '0;
            state    <= S_IDLE;
          end else begin
            node_idx <= node_idx + ADDR_WIDTH'(1);
            state    <= S_MULT;
          end
        end
        default: begin
          node_idx <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_input_mask_sequencer.sv
module tb_input_mask_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [31:0] sample_data = '0;
  logic        sample_ready;
  logic        mask_wr_en = 1'b0;
  logic [3:0]  mask_wr_addr = '0;
  logic [15:0] mask_wr_data = '0;
  logic [31:0] res_din;
  logic        res_en;
  logic        res_valid = 1'b1;
  logic [3:0]  node_idx;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  int          pulse_t[$];
  logic [31:0] pulse_d[$];
  logic [3:0]  pulse_n[$];
  bit          ack_seen, stall_bad, hs_ready;
  logic [15:0] mask_m[10];
  logic        ab_en, ab_busy, ab_ready, ab_done;
  logic [31:0] ab_din;
  logic [3:0]  ab_node, ab_pre_node;
  int          done_t;

  input_mask_sequencer dut (
    .clk(clk), .rst(rst),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
    .mask_wr_en(mask_wr_en), .mask_wr_addr(mask_wr_addr), .mask_wr_data(mask_wr_data),
    .res_din(res_din), .res_en(res_en), .res_valid(res_valid),
    .node_idx(node_idx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_mask(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    mask_wr_en = 1'b1; mask_wr_addr = a; mask_wr_data = d;
    @(negedge clk);
    mask_wr_en = 1'b0;
    if (a < 4'd10) mask_m[a] = d;
  endtask

  function automatic logic [31:0] model(input logic [31:0] s, input logic [15:0] m);
    logic [63:0] p;
    p = {32'd0, s} * {48'd0, m};
    return p[47:16];
  endfunction

  // The handshake happens at t=0. t counts cycles after it, sampled at negedge.
  task automatic run_frame(input logic [31:0] s, input int stall_node, input bit probe,
                           input int abort_t, output int dt);
    int st;
    st = -100; dt = -1;
    pulse_t.delete(); pulse_d.delete(); pulse_n.delete();
    ack_seen = 0; stall_bad = 0;
    @(negedge clk);
    sample_valid = 1'b1; sample_data = s; hs_ready = sample_ready;
    for (int t = 1; t <= 300; t++) begin
      @(negedge clk);
      if (t == 1) sample_valid = 1'b0;
      if (res_en) begin
        pulse_t.push_back(t); pulse_d.push_back(res_din); pulse_n.push_back(node_idx);
        if (stall_node >= 0 && int'(node_idx) == stall_node) begin
          res_valid = 1'b0; st = t;
        end
      end else if (t > st && t < st + 7 && int'(node_idx) != stall_node) stall_bad = 1;
      if (t > st && t < st + 7 && res_en) stall_bad = 1;
      if (t == st + 7) res_valid = 1'b1;
      if (probe) begin
        if (t == 10) begin sample_valid = 1'b1; sample_data = 32'h5555_5555; end
        if (t >= 10 && t < 20 && sample_ready) ack_seen = 1;
        if (t == 20) sample_valid = 1'b0;
        if (t == 12) begin mask_wr_en = 1'b1; mask_wr_addr = 4'd0; mask_wr_data = 16'h1234; end
        if (t == 13) mask_wr_en = 1'b0;
      end
      if (t == abort_t) begin
        ab_pre_node = node_idx;
        rst = 1'b0;
        #1;
        ab_en = res_en; ab_busy = busy; ab_ready = sample_ready;
        ab_done = frame_done; ab_din = res_din; ab_node = node_idx;
        @(negedge clk);
        rst = 1'b1;
        break;
      end
      if (frame_done) begin dt = t; break; end
    end
  endtask

  task automatic check_frame(input string tag, input logic [31:0] s, input int exp_done);
    check({tag, "_ready"}, hs_ready, 1);
    check({tag, "_done"}, done_t, exp_done);
    check({tag, "_npulse"}, pulse_d.size(), 10);
    for (int k = 0; k < 10 && k < pulse_d.size(); k++) begin
      check($sformatf("%s_din%0d", tag, k), pulse_d[k], model(s, mask_m[k]));
      check($sformatf("%s_node%0d", tag, k), pulse_n[k], k);
    end
  endtask

  initial begin
    for (int k = 0; k < 10; k++) mask_m[k] = 16'h0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", sample_ready, 1);
    check("rst_en", res_en, 0);
    check("rst_din", res_din, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_node", node_idx, 0);
    rst = 1'b1;
    @(negedge clk);

    // Masks are still at their reset value, so every injected value is 0.
    run_frame(32'hDEAD_BEEF, -1, 0, -1, done_t);
    check_frame("zero", 32'hDEAD_BEEF, 40);
    check("zero_din5_hand", pulse_d[5], 0);

    // Basic frame: mask 0.5 everywhere, sample 0x10000.
    for (int k = 0; k < 10; k++) wr_mask(k[3:0], 16'h8000);
    run_frame(32'h0001_0000, -1, 0, -1, done_t);
    check_frame("basic", 32'h0001_0000, 40);
    for (int k = 0; k < 10 && k < pulse_t.size(); k++) begin
      check($sformatf("basic_t%0d", k), pulse_t[k], 2 + 4 * k);
      check($sformatf("basic_hand%0d", k), pulse_d[k], 32'h0000_8000);
    end
    @(negedge clk);
    check("basic_ready_after", sample_ready, 1);

    // Full-scale truncation, plus a zero mask entry.
    wr_mask(4'd3, 16'hFFFF);
    wr_mask(4'd5, 16'h0000);
    run_frame(32'hFFFF_FFFF, -1, 0, -1, done_t);
    check_frame("full", 32'hFFFF_FFFF, 40);
    check("full_n3_hand", pulse_d[3], 32'hFFFE_FFFF);
    check("full_n5_hand", pulse_d[5], 32'h0);
    check("full_n0_hand", pulse_d[0], 32'h7FFF_FFFF);

    // Stall at node 2 for 5 extra cycles.
    run_frame(32'h0001_0000, 2, 0, -1, done_t);
    check_frame("stall", 32'h0001_0000, 45);
    check("stall_hold", stall_bad, 0);
    check("stall_gap", pulse_t[3] - pulse_t[2], 9);
    check("stall_gap_next", pulse_t[4] - pulse_t[3], 4);

    // Busy protections: a mid-frame mask write and a sample offered while busy.
    run_frame(32'h0001_0000, -1, 1, -1, done_t);
    check_frame("busy", 32'h0001_0000, 40);
    check("busy_noack", ack_seen, 0);
    // A write to out-of-range address 12 must not change any entry.
    wr_mask(4'd12, 16'h1234);
    run_frame(32'h0001_0000, -1, 0, -1, done_t);
    check_frame("oor", 32'h0001_0000, 40);
    check("oor_n0_hand", pulse_d[0], 32'h0000_8000);
    check("oor_n3_hand", pulse_d[3], 32'h0000_FFFF);

    // Abort with reset during node 5's SETTLE cycle (its ISSUE is at t=22).
    run_frame(32'h0001_0000, -1, 0, 23, done_t);
    check("abort_pre_node", ab_pre_node, 5);
    check("abort_npulse", pulse_d.size(), 6);
    check("abort_en", ab_en, 0);
    check("abort_busy", ab_busy, 0);
    check("abort_ready", ab_ready, 1);
    check("abort_done", ab_done, 0);
    check("abort_din", ab_din, 0);
    check("abort_node", ab_node, 0);
    ab_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (frame_done || busy) ab_done = 1;
    end
    check("abort_quiet", ab_done, 0);
    for (int k = 0; k < 10; k++) mask_m[k] = 16'h0;
    run_frame(32'h0001_0000, -1, 0, -1, done_t);
    check_frame("after", 32'h0001_0000, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
